// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-side signals between mux_scan_ctrl and its environment.
// The slave modport is the scanner; the master modport is the environment driving it.
interface mux_scan_ctrl_if #(
  parameter int unsigned DWELL_W = 4
);
  logic               start;
  logic               continuous;
  logic [DWELL_W-1:0] dwell;
  logic               mux_out;
  logic [1:0]         sel;
  logic               busy;
  logic [3:0]         word;
  logic               word_valid;
  logic               ack;

  modport slave (
    input  start, continuous, dwell, mux_out, ack,
    output sel, busy, word, word_valid
  );

  modport master (
    output start, continuous, dwell, mux_out, ack,
    input  sel, busy, word, word_valid
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Timed 4-channel sampler: steps the mux select through channels 0..3 with a programmable
// dwell, samples mux_out at each dwell end and presents the four bits with a valid/ack handshake.
module mux_scan_ctrl #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mux_scan_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dw_q, dw_d;
  logic [3:0]         shd_q, shd_d;
  logic [3:0]         word_q, word_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= 2'b00;
      cnt_q   <= '0;
      dw_q    <= '0;
      shd_q   <= 4'b0000;
      word_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dw_q    <= dw_d;
      shd_q   <= shd_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dw_d    = dw_q;
    shd_d   = shd_q;
    word_d  = word_q;

    unique case (state_q)
      StIdle: begin
        sel_d = 2'b00;
        if (bus.start) begin
          dw_d    = bus.dwell;
          cnt_d   = bus.dwell;
          state_d = StScan;
        end
      end

      StScan: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          shd_d[sel_q] = bus.mux_out;
          if (sel_q != 2'd3) begin
            sel_d = sel_q + 2'd1;
            cnt_d = dw_q;
          end else begin
            // Last channel bypasses the shadow so the word is complete on this edge.
            word_d  = {bus.mux_out, shd_q[2:0]};
            state_d = StHold;
          end
        end
      end

      StHold: begin
        if (bus.ack) begin
          sel_d = 2'b00;
          if (bus.continuous) begin
            dw_d    = bus.dwell;
            cnt_d   = bus.dwell;
            state_d = StScan;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
        sel_d   = 2'b00;
      end
    endcase
  end

  assign bus.sel        = sel_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.word_valid = (state_q == StHold);
  assign bus.word       = word_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed scenarios then randomized scans, checked
// against a cycle-count model of the dwell/sample schedule.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data = 4'b0000;  // data[k] is mux data input k+1

  int nvec = 0;
  int nerr = 0;
  logic [3:0] exp_word = 4'b0000;

  mux_scan_ctrl_if #(.DWELL_W(4)) bus ();

  assign bus.mux_out = data[bus.sel];

  mux_scan_ctrl #(.DWELL_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".sel"},   32'(bus.sel), 32'd0);
    check({tag, ".busy"},  32'(bus.busy), 32'd0);
    check({tag, ".valid"}, 32'(bus.word_valid), 32'd0);
    check({tag, ".word"},  32'(bus.word), 32'(exp_word));
  endtask

  // Called just after the scan-start edge; D cycles per channel, sample at edge (k+1)*D.
  task automatic scan_body(input int d, input bit rnd);
    logic [3:0] smp;
    smp = 4'b0000;
    for (int t = 0; t < 4 * d; t++) begin
      check("scan.sel",   32'(bus.sel), 32'(t / d));
      check("scan.busy",  32'(bus.busy), 32'd1);
      check("scan.valid", 32'(bus.word_valid), 32'd0);
      check("scan.word",  32'(bus.word), 32'(exp_word));
      if (rnd) begin
        data      = 4'($urandom);
        bus.dwell = 4'($urandom);
        bus.start = 1'($urandom);
        bus.ack   = 1'($urandom);
      end else if (t == 1) begin
        bus.dwell = 4'd7;
      end
      if ((t + 1) % d == 0) smp[(t + 1) / d - 1] = data[(t + 1) / d - 1];
      step();
    end
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    exp_word  = smp;
    check("done.valid", 32'(bus.word_valid), 32'd1);
    check("done.busy",  32'(bus.busy), 32'd1);
    check("done.sel",   32'(bus.sel), 32'd3);
    check("done.word",  32'(bus.word), 32'(exp_word));
  endtask

  task automatic start_scan(input int dw, input bit rnd);
    bus.dwell = 4'(dw);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    scan_body(dw + 1, rnd);
  endtask

  task automatic hold(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        data      = 4'($urandom);
        bus.start = 1'($urandom);
      end else begin
        bus.start = ~bus.start;
      end
      step();
      check("hold.valid", 32'(bus.word_valid), 32'd1);
      check("hold.busy",  32'(bus.busy), 32'd1);
      check("hold.sel",   32'(bus.sel), 32'd3);
      check("hold.word",  32'(bus.word), 32'(exp_word));
    end
    bus.start = 1'b0;
  endtask

  task automatic finish_hold(input bit cont, input int newdw, input bit rnd);
    bus.continuous = cont;
    bus.dwell      = 4'(newdw);
    bus.ack        = 1'b1;
    step();
    bus.ack = 1'b0;
    if (cont) scan_body(newdw + 1, rnd);
    else check_idle("ack_idle");
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.dwell      = 4'd0;
    bus.ack        = 1'b0;

    // Reset, then ack in IDLE is ignored
    step();
    step();
    reset = 1'b0;
    check_idle("reset");
    bus.ack = 1'b1;
    repeat (3) step();
    check_idle("idle_ack");
    bus.ack = 1'b0;

    // Single shot, dwell 0
    data = 4'b1010;
    start_scan(0, 1'b0);
    check("ss.word", 32'(bus.word), 32'hA);
    finish_hold(1'b0, 0, 1'b0);

    // Dwell 3, dwell input changed to 7 mid-scan
    data = 4'b0110;
    start_scan(3, 1'b0);
    check("dw.word", 32'(bus.word), 32'h6);

    // Backpressure with changing data and start pulses
    data = 4'b1111;
    hold(20, 1'b0);
    finish_hold(1'b0, 0, 1'b0);
    check("bp.word", 32'(bus.word), 32'h6);

    // Continuous, dwell 1
    data = 4'b1001;
    start_scan(1, 1'b0);
    check("ct.word1", 32'(bus.word), 32'h9);
    data = 4'b0101;
    finish_hold(1'b1, 1, 1'b0);
    check("ct.word2", 32'(bus.word), 32'h5);
    finish_hold(1'b0, 0, 1'b0);

    // Reset after channel 2 sampled (D=3, edge 9)
    data      = 4'($urandom);
    bus.dwell = 4'd2;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    step();
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    exp_word  = 4'b0000;
    check_idle("mid_reset");
    data = 4'($urandom);
    start_scan(2, 1'b1);
    finish_hold(1'b0, 0, 1'b1);

    // Randomized scans and continuous chains
    for (int n = 0; n < 12; n++) begin
      start_scan(int'($urandom_range(0, 15)), 1'b1);
      for (int j = 0; j < 3; j++) begin
        bit c;
        hold(int'($urandom_range(0, 5)), 1'b1);
        c = (j < 2) ? 1'($urandom) : 1'b0;
        finish_hold(c, int'($urandom_range(0, 15)), 1'b1);
        if (!c) break;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequential front end for the 4:1 `mux`. It drives the mux's two select lines through channels 0..3 with a programmable dwell per channel, samples the mux output at the end of each dwell, and presents the four samples as one parallel word with a valid/ack handshake. It supports single-shot and continuous scanning, turning the purely combinational selector into a timed 4-channel sampler.

## Interface
Parameters:
- `DWELL_W`, 4: width of the dwell input and the internal dwell counter.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request a scan; sampled only in IDLE.
- `continuous`  in  1: sampled on handshake completion; 1 starts a new scan immediately, 0 returns to IDLE.
- `dwell`  in  `DWELL_W`: each channel is held for `dwell`+1 cycles; latched at scan start.
- `mux_out`  in  1: output of the mux.
- `sel`  out  2: mux select. `sel[0]` drives the first mux select input and `sel[1]` the second. Channel k selects mux data input k+1.
- `busy`  out  1: high in SCAN and HOLD.
- `word`  out  4: `word[k]` is the sample of channel k from the last completed scan.
- `word_valid`  out  1: high in HOLD.
- `ack`  in  1: consumer accepts `word`.

## Operation
- States: IDLE, SCAN, HOLD.
- Registers: `sel`, the dwell counter `cnt` (`DWELL_W` bits), the latched dwell value `dw`, the 4-bit shadow sample register `shd`, and `word`.
- IDLE:
  - `sel`=0, `busy`=0, `word_valid`=0.
  - If `start`=1: `dw`←`dwell`, `cnt`←`dwell`, `sel`←0, go to SCAN.
- SCAN:
  - If `cnt`≠0: `cnt`←`cnt`−1.
  - If `cnt`=0: `shd[sel]`←`mux_out`.
    - If `sel`≠3: `sel`←`sel`+1, `cnt`←`dw`.
    - If `sel`=3: `word`←{`mux_out`, `shd[2:0]`}, go to HOLD. `sel` stays at 3.
  - `start` is ignored.
  - A change on the `dwell` input does not affect a scan in progress.
- HOLD:
  - `word_valid`=1. `word` is stable.
  - On `ack`=1 the handshake completes at that edge:
    - If `continuous`=1: `sel`←0, `dw`←`dwell`, `cnt`←`dwell`, go to SCAN.
    - Otherwise go to IDLE with `sel`←0.
  - With `ack`=0 the block stays in HOLD indefinitely.
- `ack` outside HOLD is ignored.
- `word` changes only on scan completion. It keeps its previous value during later scans, and after IDLE.
- `dwell`=0 gives 1 cycle per channel. The maximum dwell, 2^`DWELL_W`−1, gives 2^`DWELL_W` cycles per channel. There is no counter wrap beyond that.

## Timing
- Reset values:
  - State IDLE.
  - `sel`=2'b00, `busy`=0, `word`=4'b0000, `word_valid`=0.
  - `cnt`, `dw` and `shd` are 0.
- Reset mid-scan or in HOLD:
  - The next edge forces the reset values.
  - Partial samples and the pending word are discarded, and `word` clears to 0.
  - Reset has priority over `start` and `ack`.
- Let D=`dw`+1. If `start` is sampled at edge 0:
  - `busy`=1 and `sel`=0 from after edge 0.
  - Channel k is sampled at edge (k+1)·D.
  - `sel` advances immediately after each sample edge for k<3.
  - `word_valid` rises after edge 4D, so start-to-valid latency is 4D cycles.
- The mux is combinational, so `mux_out` has D−1 full cycles plus the sampling cycle to settle after each `sel` change.
- Handshake completion:
  - `ack` sampled at edge A in HOLD drops `word_valid` after A.
  - In continuous mode the next word is valid 4D cycles after A.
- `busy` falls after the completing `ack` edge only when `continuous`=0.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then idle: after reset, `sel`=00, `busy`=0, `word_valid`=0, `word`=0000. `ack`=1 in IDLE has no effect.
- Single shot, `dwell`=0, mux data {in4..in1}=1010, `start` pulse at edge 0, `continuous`=0:
  - `sel` reads 0,1,2,3 on successive cycles.
  - `word_valid` rises after edge 4 with `word`=1010.
  - `ack` returns the block to IDLE and `word` holds 1010.
- Dwell, `dwell`=3 with data 0110:
  - Each `sel` value is held 4 cycles and `word_valid` rises after edge 16 with `word`=0110.
  - Changing `dwell` to 7 mid-scan does not alter this timing.
- Backpressure: hold `ack`=0 for 20 cycles in HOLD while the mux data changes to 1111.
  - `word` stays 0110 and `word_valid` stays 1.
  - `start` pulses are ignored.
- Continuous, `dwell`=1, data 1001 then 0101:
  - `ack` at edge A restarts the scan.
  - The next `word_valid` comes 8 cycles after A with `word`=0101.
  - `word` reads 1001 until then.
- Reset mid-scan after channel 2 is sampled: the next cycle shows the reset values, and a new `start` produces a full 4D-cycle scan.
